regfile_wb_arbiter: RTL and testbench

Write-back arbiter and register scoreboard for the 32×32 register file. It shares the register file's single write port between two producers: port 0, the ALU write-back, and port 1, the load/multicycle unit. Each accepted write is registered and presented to the register file as a one-cycle write strobe. Per-register busy bits give the decode stage a stall signal for source operands whose producer has not yet written back.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-request record used by the
// write-back arbiter and its consumers.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: a lone requester always wins, a tie goes
// to the port that was not granted most recently.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last;

  // Grants are suppressed during reset so no producer sees an acknowledge.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU and load/multicycle
// write-back paths and tracks pending destinations for decode stalls.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       busy_vec
);

  logic [1:0]          req_p0;
  logic [1:0]          gnt_p0;
  logic                any_gnt_p0;
  wr_req_t             sel_p0;

  logic                wr_p1;
  logic [ADDR_W-1:0]   wr_addr_p1;
  logic [DATA_W-1:0]   wr_data_p1;
  logic [NUM_REGS-1:0] busy_p1;
  logic [NUM_REGS-1:0] busy_nxt;

  // Stage p0: arbitration and selection of the winning request
  assign req_p0     = {req1_valid, req0_valid};
  assign any_gnt_p0 = |gnt_p0;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_p0),
    .advance (any_gnt_p0),
    .gnt     (gnt_p0)
  );

  assign req0_ready = gnt_p0[0];
  assign req1_ready = gnt_p0[1];

  always_comb begin
    if (gnt_p0[1]) begin
      sel_p0.addr = req1_addr;
      sel_p0.data = req1_data;
    end else begin
      sel_p0.addr = req0_addr;
      sel_p0.data = req0_data;
    end
  end

  // Stage p1: registered write strobe to the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_p1      <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_p1 <= any_gnt_p0 && (sel_p0.addr != ZERO_REG);
      if (any_gnt_p0) begin
        wr_addr_p1 <= sel_p0.addr;
        wr_data_p1 <= sel_p0.data;
      end
    end
  end

  // A claim landing on the same edge as the clear wins: a newer producer is outstanding.
  always_comb begin
    busy_nxt = busy_p1;
    if (wr_p1) begin
      busy_nxt[wr_addr_p1] = 1'b0;
    end
    if (claim_valid && (claim_addr != ZERO_REG)) begin
      busy_nxt[claim_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_p1 <= '0;
    end else begin
      busy_p1 <= busy_nxt;
    end
  end

  assign wr       = wr_p1;
  assign wr_addr  = wr_addr_p1;
  assign wr_data  = wr_data_p1;
  assign busy_vec = busy_p1;
  assign rs_busy  = busy_p1[rs];
  assign rt_busy  = busy_p1[rt];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the write-back arbiter and scoreboard.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        claim_valid;
  logic [4:0]  claim_addr;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rs_busy;
  logic        rt_busy;
  logic        wr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy_vec;

  int total;
  int bad;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .rs          (rs),
    .rt          (rt),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .wr          (wr),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    claim_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req0_addr = 5'd9; req0_data = 32'h1; req1_addr = 5'd10; req1_data = 32'h2;
    claim_addr = 5'd0; rs = 5'd0; rt = 5'd0;
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    #2;
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready);
    end
    total++;
    if (wr !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
      bad++; $display("FAIL reset_wr: got wr=%b addr=%0d data=%h want 0/0/0", wr, wr_addr, wr_data);
    end
    total++;
    if (busy_vec !== 32'd0) begin
      bad++; $display("FAIL reset_busy: got %h want 0", busy_vec);
    end
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    #2;
    total++;
    if (wr !== 1'b0 || busy_vec !== 32'd0) begin
      bad++; $display("FAIL idle_after_reset: got wr=%b busy=%h want 0/0", wr, busy_vec);
    end
  endtask

  task automatic test_single_write();
    claim_valid = 1'b1; claim_addr = 5'd5; rs = 5'd5; rt = 5'd0;
    tick();
    claim_valid = 1'b0;
    #2;
    total++;
    if (busy_vec !== 32'h0000_0020 || rs_busy !== 1'b1 || rt_busy !== 1'b0) begin
      bad++; $display("FAIL claim_r5: got busy=%h rs_busy=%b rt_busy=%b want 00000020/1/0", busy_vec, rs_busy, rt_busy);
    end
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    #2;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL single_ready: got %b%b want 01", req1_ready, req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    #2;
    total++;
    if (wr !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL single_wr: got wr=%b addr=%0d data=%h want 1/5/deadbeef", wr, wr_addr, wr_data);
    end
    total++;
    if (rs_busy !== 1'b1) begin
      bad++; $display("FAIL single_busy_n1: got rs_busy=%b want 1", rs_busy);
    end
    tick();
    #2;
    total++;
    if (wr !== 1'b0 || busy_vec !== 32'd0 || rs_busy !== 1'b0) begin
      bad++; $display("FAIL single_clear: got wr=%b busy=%h rs_busy=%b want 0/0/0", wr, busy_vec, rs_busy);
    end
  endtask

  task automatic test_zero_reg();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
    claim_valid = 1'b1; claim_addr = 5'd0;
    #2;
    total++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      bad++; $display("FAIL zero_ready: got %b%b want 10", req1_ready, req0_ready);
    end
    tick();
    idle_inputs();
    #2;
    total++;
    if (wr !== 1'b0 || busy_vec !== 32'd0) begin
      bad++; $display("FAIL zero_wr: got wr=%b busy=%h want 0/0", wr, busy_vec);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt  [4];
    logic [4:0]  exp_addr [4];
    logic [31:0] exp_data [4];
    int n0;
    int n1;
    exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr = '{5'd1, 5'd2, 5'd1, 5'd2};
    exp_data = '{32'h1000, 32'h2000, 32'h1001, 32'h2001};
    n0 = 0;
    n1 = 0;
    req0_valid = 1'b1; req0_addr = 5'd1;
    req1_valid = 1'b1; req1_addr = 5'd2;
    for (int i = 0; i < 4; i++) begin
      req0_data = 32'h1000 + n0;
      req1_data = 32'h2000 + n1;
      #2;
      total++;
      if ({req1_ready, req0_ready} !== exp_gnt[i]) begin
        bad++; $display("FAIL contention_gnt[%0d]: got %b%b want %b", i, req1_ready, req0_ready, exp_gnt[i]);
      end
      if (i > 0) begin
        total++;
        if (wr !== 1'b1 || wr_addr !== exp_addr[i-1] || wr_data !== exp_data[i-1]) begin
          bad++; $display("FAIL contention_wr[%0d]: got wr=%b addr=%0d data=%h want 1/%0d/%h",
                          i-1, wr, wr_addr, wr_data, exp_addr[i-1], exp_data[i-1]);
        end
      end
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      tick();
    end
    idle_inputs();
    #2;
    total++;
    if (wr !== 1'b1 || wr_addr !== exp_addr[3] || wr_data !== exp_data[3]) begin
      bad++; $display("FAIL contention_wr[3]: got wr=%b addr=%0d data=%h want 1/%0d/%h",
                      wr, wr_addr, wr_data, exp_addr[3], exp_data[3]);
    end
    tick();
  endtask

  task automatic test_collision();
    claim_valid = 1'b1; claim_addr = 5'd7; rs = 5'd7; rt = 5'd7;
    tick();
    claim_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
    #2;
    total++;
    if (req0_ready !== 1'b1 || busy_vec !== 32'h0000_0080) begin
      bad++; $display("FAIL collide_setup: got ready=%b busy=%h want 1/00000080", req0_ready, busy_vec);
    end
    tick();
    req0_valid = 1'b0;
    claim_valid = 1'b1; claim_addr = 5'd7;
    #2;
    total++;
    if (wr !== 1'b1 || wr_addr !== 5'd7) begin
      bad++; $display("FAIL collide_pending: got wr=%b addr=%0d want 1/7", wr, wr_addr);
    end
    tick();
    claim_valid = 1'b0;
    #2;
    total++;
    if (busy_vec !== 32'h0000_0080 || rs_busy !== 1'b1 || rt_busy !== 1'b1) begin
      bad++; $display("FAIL collide_set_wins: got busy=%h rs_busy=%b rt_busy=%b want 00000080/1/1", busy_vec, rs_busy, rt_busy);
    end
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h78;
    tick();
    req1_valid = 1'b0;
    tick();
    #2;
    total++;
    if (busy_vec !== 32'd0 || rs_busy !== 1'b0) begin
      bad++; $display("FAIL collide_cleanup: got busy=%h rs_busy=%b want 0/0", busy_vec, rs_busy);
    end
  endtask

  task automatic test_reset_mid_write();
    claim_valid = 1'b1; claim_addr = 5'd3; rs = 5'd3;
    tick();
    claim_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    #2;
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_grant: got ready=%b want 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
    rst = 1'b1;
    #2;
    total++;
    if (wr !== 1'b1 || req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_during: got wr=%b ready=%b%b want 1/00", wr, req1_ready, req0_ready);
    end
    tick();
    #2;
    total++;
    if (wr !== 1'b0 || busy_vec !== 32'd0 || wr_addr !== 5'd0 || rs_busy !== 1'b0) begin
      bad++; $display("FAIL midrst_after: got wr=%b busy=%h addr=%0d rs_busy=%b want 0/0/0/0", wr, busy_vec, wr_addr, rs_busy);
    end
    rst = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_write();
    test_zero_reg();
    test_contention();
    test_collision();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
